// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Brief    : Shared async-FIFO helpers (Gray/binary conversion, defaults)
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_ADDRSIZE   = 4;
    // Conversion helpers work on a wide vector; callers size-cast in and out.
    localparam int c_GRAY_MAX_W = 32;

    function automatic logic [c_GRAY_MAX_W-1:0] bin2gray(input logic [c_GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits decode to zero, so any narrower pointer converts correctly.
    function automatic logic [c_GRAY_MAX_W-1:0] gray2bin(input logic [c_GRAY_MAX_W-1:0] g);
        logic [c_GRAY_MAX_W-1:0] b;
        b[c_GRAY_MAX_W-1] = g[c_GRAY_MAX_W-1];
        for (int i = c_GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_w2r.sv
`default_nettype none
// ============================================================================
//  Module   : sync_w2r
//  Brief    : Two-flop synchronizer bringing the Gray write pointer into rclk
//  Revision : 1.0 - initial release
// ============================================================================
module sync_w2r
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = c_ADDRSIZE
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic [ADDRSIZE:0] wptr,
    output logic [ADDRSIZE:0] rq2_wptr
);

    logic [ADDRSIZE:0] r_q1_wptr;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_q1_wptr <= '0;
            rq2_wptr  <= '0;
        end else begin
            r_q1_wptr <= wptr;
            rq2_wptr  <= r_q1_wptr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rptr_empty.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rptr_empty
//  Brief    : Async-FIFO read pointer, empty/almost-empty, level and underflow
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_rptr_empty
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE      = c_ADDRSIZE,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                runderflow
);

    localparam int                c_PTR_W         = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] c_AEMPTY_THRESH = c_PTR_W'(AEMPTY_THRESH);

    logic [ADDRSIZE:0] r_bin;
    logic [ADDRSIZE:0] w_rq2_wptr;
    logic [ADDRSIZE:0] w_wq2_bin;
    logic [ADDRSIZE:0] w_bin_next;
    logic [ADDRSIZE:0] w_gray_next;
    logic [ADDRSIZE:0] w_level_next;
    logic              w_rd_en;
    logic              w_aempty_next;

    sync_w2r #(
        .ADDRSIZE (ADDRSIZE)
    ) u_sync_w2r (
        .rclk     (rclk),
        .rrst     (rrst),
        .wptr     (wptr),
        .rq2_wptr (w_rq2_wptr)
    );

    always_comb begin
        w_rd_en       = rinc & ~rempty;
        w_bin_next    = r_bin + {{ADDRSIZE{1'b0}}, w_rd_en};
        w_gray_next   = c_PTR_W'(bin2gray(c_GRAY_MAX_W'(w_bin_next)));
        w_wq2_bin     = c_PTR_W'(gray2bin(c_GRAY_MAX_W'(w_rq2_wptr)));
        // Modulo subtraction keeps the level right across pointer wrap.
        w_level_next  = w_wq2_bin - w_bin_next;
        w_aempty_next = (w_level_next <= c_AEMPTY_THRESH);
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_bin      <= '0;
            rptr       <= '0;
            rempty     <= 1'b1;
            raempty    <= 1'b1;
            rlevel     <= '0;
            runderflow <= 1'b0;
        end else begin
            r_bin      <= w_bin_next;
            rptr       <= w_gray_next;
            // Full-width compare including the wrap bit; a write still in the
            // synchronizer keeps the flag pessimistically set.
            rempty     <= (w_gray_next == w_rq2_wptr);
            raempty    <= w_aempty_next;
            rlevel     <= w_level_next;
            runderflow <= runderflow | (rinc & rempty);
        end
    end

    assign raddr = r_bin[ADDRSIZE-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fifo_rptr_empty.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_rptr_empty
//  Brief    : Directed vector table plus wrap and full-occupancy sequences
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_rptr_empty;

    localparam int c_AW = 4;

    logic              rclk = 1'b0;
    logic              rrst;
    logic              rinc;
    logic [c_AW:0]     wptr;
    logic [c_AW:0]     rptr;
    logic [c_AW-1:0]   raddr;
    logic              rempty;
    logic              raempty;
    logic [c_AW:0]     rlevel;
    logic              runderflow;

    int n_vec = 0;
    int n_bad = 0;

    always #5 rclk = ~rclk;

    fifo_rptr_empty #(
        .ADDRSIZE      (c_AW),
        .AEMPTY_THRESH (2)
    ) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .rinc       (rinc),
        .wptr       (wptr),
        .rptr       (rptr),
        .raddr      (raddr),
        .rempty     (rempty),
        .raempty    (raempty),
        .rlevel     (rlevel),
        .runderflow (runderflow)
    );

    typedef struct {
        logic          rst;
        logic          inc;
        logic [c_AW:0] wp;
        logic          e_empty;
        logic          e_aempty;
        logic [c_AW:0] e_rptr;
        logic [3:0]    e_raddr;
        logic [c_AW:0] e_level;
        logic          e_under;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [c_AW:0] gray(input logic [c_AW:0] b);
        return b ^ (b >> 1);
    endfunction

    // Drive inputs, take one rising edge, settle 1 ns past it.
    task automatic step(input logic r, input logic i, input logic [c_AW:0] w);
        rrst = r;
        rinc = i;
        wptr = w;
        @(posedge rclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic e_empty, input logic e_aempty,
                       input logic [c_AW:0] e_rptr, input logic [3:0] e_raddr,
                       input logic [c_AW:0] e_level, input logic e_under);
        n_vec++;
        if ({rempty, raempty, rptr, raddr, rlevel, runderflow} !==
            {e_empty, e_aempty, e_rptr, e_raddr, e_level, e_under}) begin
            n_bad++;
            $display("FAIL %s: got empty=%b aempty=%b rptr=%b raddr=%0d level=%0d under=%b, expected empty=%b aempty=%b rptr=%b raddr=%0d level=%0d under=%b",
                     nm, rempty, raempty, rptr, raddr, rlevel, runderflow,
                     e_empty, e_aempty, e_rptr, e_raddr, e_level, e_under);
        end
    endtask

    // Reference state for the wrap sequence
    int   m_rbin, m_wq1, m_wq2, m_lvl, wcnt, max_lvl;
    logic m_empty, m_under, saw_wrap;
    logic [c_AW:0] prev_rptr;

    initial begin
        rrst = 1'b1;
        rinc = 1'b0;
        wptr = '0;

        //            rst inc wptr      emp aem rptr      raddr lvl under
        tbl.push_back('{1, 1, 5'b00011, 1, 1, 5'b00000, 0, 0, 0}); // reset, rinc ignored
        tbl.push_back('{0, 0, 5'b00001, 1, 1, 5'b00000, 0, 0, 0}); // wptr -> Gray 1
        tbl.push_back('{0, 0, 5'b00001, 1, 1, 5'b00000, 0, 0, 0});
        tbl.push_back('{0, 0, 5'b00001, 0, 1, 5'b00000, 0, 1, 0}); // empty falls 3rd edge
        tbl.push_back('{0, 0, 5'b00011, 0, 1, 5'b00000, 0, 1, 0}); // Gray 2
        tbl.push_back('{0, 0, 5'b00010, 0, 1, 5'b00000, 0, 1, 0}); // Gray 3
        tbl.push_back('{0, 0, 5'b00110, 0, 1, 5'b00000, 0, 2, 0}); // Gray 4
        tbl.push_back('{0, 0, 5'b00111, 0, 0, 5'b00000, 0, 3, 0}); // Gray 5
        tbl.push_back('{0, 0, 5'b00111, 0, 0, 5'b00000, 0, 4, 0});
        tbl.push_back('{0, 0, 5'b00111, 0, 0, 5'b00000, 0, 5, 0});
        tbl.push_back('{0, 0, 5'b00111, 0, 0, 5'b00000, 0, 5, 0});
        tbl.push_back('{0, 1, 5'b00111, 0, 0, 5'b00001, 1, 4, 0}); // read @0
        tbl.push_back('{0, 1, 5'b00111, 0, 0, 5'b00011, 2, 3, 0}); // read @1
        tbl.push_back('{0, 1, 5'b00111, 0, 1, 5'b00010, 3, 2, 0}); // read @2
        tbl.push_back('{0, 1, 5'b00111, 0, 1, 5'b00110, 4, 1, 0}); // read @3
        tbl.push_back('{0, 1, 5'b00111, 1, 1, 5'b00111, 5, 0, 0}); // read @4, empty rises
        tbl.push_back('{0, 1, 5'b00111, 1, 1, 5'b00111, 5, 0, 1}); // underflow
        tbl.push_back('{0, 0, 5'b00111, 1, 1, 5'b00111, 5, 0, 1}); // sticky
        tbl.push_back('{1, 1, 5'b00111, 1, 1, 5'b00000, 0, 0, 0}); // reset clears it

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].rst, tbl[k].inc, tbl[k].wp);
            chk($sformatf("vec%0d", k), tbl[k].e_empty, tbl[k].e_aempty, tbl[k].e_rptr,
                tbl[k].e_raddr, tbl[k].e_level, tbl[k].e_under);
        end

        // Wrap-around: 40 writes interleaved with reads against a reference model
        m_rbin = 0; m_wq1 = 0; m_wq2 = 0; wcnt = 0; max_lvl = 0;
        m_empty = 1'b1; m_under = 1'b0; saw_wrap = 1'b0;
        prev_rptr = rptr;
        for (int cyc = 0; cyc < 160; cyc++) begin
            int   nb;
            logic rd;
            logic ri;
            if (wcnt < 40 && (cyc % 3) != 2 && ((wcnt - m_rbin) & 31) < 16)
                wcnt++;
            ri = ((cyc % 4) != 0);
            step(1'b0, ri, gray(5'(wcnt)));
            rd      = ri && !m_empty;
            nb      = (m_rbin + int'(rd)) & 31;
            m_lvl   = (m_wq2 - nb) & 31;
            m_under = m_under | (ri & m_empty);
            m_empty = (nb == m_wq2);
            m_wq2   = m_wq1;
            m_wq1   = wcnt & 31;
            m_rbin  = nb;
            if (m_lvl > max_lvl) max_lvl = m_lvl;
            chk($sformatf("wrap%0d", cyc), m_empty, (m_lvl <= 2), gray(5'(nb)),
                4'(nb), 5'(m_lvl), m_under);
            if (prev_rptr == 5'b10000 && rptr == 5'b00000) saw_wrap = 1'b1;
            prev_rptr = rptr;
        end
        n_vec++;
        if (!saw_wrap || max_lvl > 16 || rlevel > 5'd16) begin
            n_bad++;
            $display("FAIL wrap_seen: got saw_wrap=%b max_level=%0d, expected saw_wrap=1 max_level<=16",
                     saw_wrap, max_lvl);
        end

        // Full occupancy: 16 Gray steps of wptr with no reads
        step(1'b1, 1'b0, 5'b00000);
        chk("full_reset", 1, 1, 5'b00000, 0, 0, 0);
        for (int j = 1; j <= 16; j++) step(1'b0, 1'b0, gray(5'(j)));
        step(1'b0, 1'b0, 5'b11000);
        step(1'b0, 1'b0, 5'b11000);
        chk("full16", 0, 0, 5'b00000, 0, 16, 0);
        step(1'b0, 1'b1, 5'b11000);
        chk("full_read1", 0, 0, 5'b00001, 1, 15, 0);
        // Reset mid-stream with rinc high
        step(1'b1, 1'b1, 5'b11000);
        chk("midstream_reset", 1, 1, 5'b00000, 0, 0, 0);
        step(1'b0, 1'b0, 5'b11000);
        chk("post_reset", 1, 1, 5'b00000, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
